// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width: it must hold WIDTH+1, the number of Booth steps
    // needed for a (WIDTH+1)-bit multiplier.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator, then a one-bit arithmetic right shift of {A,Q,q_m1}.
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] acc_i,   // accumulator A
    input  logic [WIDTH:0]   q_i,     // multiplier / low product bits Q
    input  logic             qm1_i,   // Booth guard bit q_-1
    input  logic [WIDTH+1:0] m_i,     // multiplicand, sign-extended
    output logic [WIDTH+1:0] acc_o,
    output logic [WIDTH:0]   q_o,
    output logic             qm1_o
);

    logic [WIDTH+1:0] sum;

    // Booth recoding of the pair {Q[0], q_-1}: 10 subtracts, 01 adds, else hold.
    always_comb begin
        sum = acc_i;
        case ({q_i[0], qm1_i})
            2'b10:   sum = acc_i - m_i;
            2'b01:   sum = acc_i + m_i;
            default: sum = acc_i;
        endcase
    end

    // Arithmetic shift: A's MSB is replicated, A's LSB moves into Q, and
    // Q's LSB becomes the new guard bit.
    assign acc_o = {sum[WIDTH+1], sum[WIDTH+1:1]};
    assign q_o   = {sum[0], q_i[WIDTH:1]};
    assign qm1_o = q_i[0];

endmodule

// File: rtl/seq_booth_multplr.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock.
// Operands are widened to WIDTH+1 bits so unsigned values become positive
// two's-complement numbers; a single signed Booth datapath then covers both
// modes. A is WIDTH+2 bits so that no intermediate add/sub can overflow.
module seq_booth_multplr
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
    localparam int PW = 2 * WIDTH;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [QW-1:0]   mq_q, mq_d;
    logic            qm1_q, qm1_d;
    logic [AW-1:0]   m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;

    logic [AW-1:0]   step_acc;
    logic [QW-1:0]   step_q;
    logic            step_qm1;

    // Extension bits of the incoming operands (zero in unsigned mode).
    logic            a_ext_bit;
    logic            b_ext_bit;

    assign a_ext_bit = is_signed & a[WIDTH-1];
    assign b_ext_bit = is_signed & b[WIDTH-1];

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (mq_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .qm1_o (step_qm1)
    );

    // Next-state logic: operand load on accepted start, one Booth step per
    // RUN cycle, result capture on the final step.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d   = '0;
                    mq_d    = {b_ext_bit, b};
                    qm1_d   = 1'b0;
                    m_d     = {{2{a_ext_bit}}, a};
                    cnt_d   = CW'(WIDTH + 1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                mq_d  = step_q;
                qm1_d = step_qm1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    // Exact result lives in the low 2*WIDTH bits of {A,Q}.
                    product_d = {step_acc[WIDTH-2:0], step_q};
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_booth_multplr.sv
// Directed and random checks of seq_booth_multplr at WIDTH=8.
module tb_seq_booth_multplr;

    localparam int W       = 8;
    localparam int LAT     = W + 1;   // edges from accept to done
    localparam int TIMEOUT = 40;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_booth_multplr #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        int xi;
        int yi;
        int p;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return p[2*W-1:0];
    endfunction

    // Issue one operation (DUT must be ready at the next negedge) and wait for
    // done. Inputs are scrambled after acceptance to show they are not re-sampled.
    task automatic run_op(input logic sgn, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          output logic [2*W-1:0] prod, output int lat,
                          output int busy_cnt, output int ready_bad);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; a = xa; b = xb;
        @(posedge clk);
        #1;
        start = 1'b0; is_signed = ~sgn; a = ~xa; b = xb ^ 8'h5A;
        busy_cnt  = busy ? 1 : 0;
        ready_bad = ready ? 1 : 0;
        lat = 0;
        prod = '0;
        while (lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                prod = product;
                break;
            end
            if (busy) busy_cnt++;
            if (ready) ready_bad++;
        end
        $display("op sgn=%0b a=%02h b=%02h product=%04h latency=%0d", sgn, xa, xb, prod, lat);
    endtask

    initial begin
        logic [2*W-1:0] prod;
        int lat, bcnt, rbad, dones, n;

        vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[3]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[4]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[5]  = '{1'b1, 8'h00, 8'hAB, 16'h0000};
        vecs[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[7]  = '{1'b0, 8'h0C, 8'h0D, 16'h009C};
        vecs[8]  = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
        vecs[9]  = '{1'b0, 8'hFE, 8'h03, 16'h02FA};
        vecs[10] = '{1'b1, 8'h03, 8'hFB, 16'hFFF1};
        vecs[11] = '{1'b0, 8'h7F, 8'h80, 16'h3F80};

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, prod, lat, bcnt, rbad);
            chk($sformatf("vec%0d_product", i), 32'(prod), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(LAT));
            chk($sformatf("vec%0d_ready_in_run", i), 32'(rbad), 32'd0);
            @(negedge clk);   // let DONE expire into IDLE
        end

        // Start pulse while busy must be ignored.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; a = 8'd3; b = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0; rbad = 0; n = 0; prod = '0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 4) begin
                @(negedge clk);
                start = 1'b1; a = 8'd9; b = 8'd9;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dones++;
                prod = product;
                if (n == 0) n = i;
            end
            if (busy && ready) rbad++;
        end
        $display("op busy-start a=03 b=05 product=%04h dones=%0d", prod, dones);
        chk("busy_start_dones", 32'(dones), 32'd1);
        chk("busy_start_product", 32'(prod), 32'h000F);
        chk("busy_start_latency", 32'(n), 32'(LAT));
        chk("busy_start_ready", 32'(rbad), 32'd0);

        // Back-to-back: start in the DONE cycle of the previous op.
        run_op(1'b0, 8'd3, 8'd5, prod, lat, bcnt, rbad);
        chk("b2b_first_product", 32'(prod), 32'h000F);
        @(negedge clk);
        chk("b2b_done_at_start", 32'(done), 32'd1);
        start = 1'b1; is_signed = 1'b1; a = 8'hFE; b = 8'h03;
        n = 0; rbad = 0; prod = '0;
        while (n < TIMEOUT) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) begin
                prod = product;
                break;
            end
            if (product !== 16'h000F) rbad++;
        end
        $display("op b2b sgn=1 a=fe b=03 product=%04h edges=%0d", prod, n);
        chk("b2b_hold_first", 32'(rbad), 32'd0);
        chk("b2b_second_edges", 32'(n), 32'(LAT + 1));
        chk("b2b_second_product", 32'(prod), 32'hFFFA);
        @(negedge clk);

        // Reset mid-operation, with start asserted alongside reset.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 8'h12; b = 8'h34;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; start = 1'b0;
        chk("midreset_ready", 32'(ready), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_product", 32'(product), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        $display("op reset-abort dones_after=%0d", dones);
        chk("midreset_no_done", 32'(dones), 32'd0);
        run_op(1'b0, 8'h12, 8'h34, prod, lat, bcnt, rbad);
        chk("after_reset_product", 32'(prod), 32'h03A8);
        chk("after_reset_latency", 32'(lat), 32'(LAT));

        // Random operands against a plain multiply reference.
        for (int i = 0; i < 300; i++) begin
            logic           rs;
            logic [W-1:0]   ra;
            logic [W-1:0]   rb;
            rs = 1'($urandom_range(1));
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(rs, ra, rb, prod, lat, bcnt, rbad);
            chk($sformatf("rand%0d_product", i), 32'(prod), 32'(ref_mul(rs, ra, rb)));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_booth_multplr.md
Name: seq_booth_multplr

Overview:
- Parametrised, iterative radix-2 Booth multiplier: one add/sub-and-arithmetic-shift step per clock, with start/ready/done handshake.
- Selectable signed or unsigned operand interpretation per operation.
- Successor to the team's combinational 4-bit Booth multiplier, for datapaths that trade latency for area at any operand width.

Parameters:
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a multiply; accepted only while ready=1
- is_signed  input  1  1: a, b are two's complement; 0: unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- ready  output  1  block can accept start this cycle
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse: product valid
- product  output  2*WIDTH  result; held until the next accepted start

Behaviour:
- Reset: synchronous active-low; on a clk edge with rst_n=0, all state is cleared. Outputs after reset: ready=1, busy=0, done=0, product=0, FSM=IDLE. Applies mid-operation too; the in-flight result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge: latch operands, extending each to WIDTH+1 bits (sign-extend if is_signed, else zero-extend).
  - Load A=0 (WIDTH+2 bits), Q=extended b, q_m1=0, cnt=WIDTH+1. Go to RUN.
- RUN (busy=1, ready=0), each cycle:
  - {Q[0],q_m1}=10: A=A−M.
  - {Q[0],q_m1}=01: A=A+M.
  - 00/11: no add.
  - M is the extended a, sign-extended to WIDTH+2 bits.
  - Then arithmetic right shift of {A,Q,q_m1} by 1, replicating A MSB.
  - cnt decrements; when cnt reaches 0 after the step, go to DONE.
- DONE (done=1, ready=1, busy=0, one cycle):
  - product = low 2*WIDTH bits of {A,Q} after the final shift.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back, no bubble), transitions to RUN. Otherwise go to IDLE.
- Latency:
  - start accepted at edge k → done high in the cycle after edge k+WIDTH+1 (WIDTH+1 RUN cycles).
  - Identical latency for both modes; throughput one result per WIDTH+2 cycles.
- Handshake:
  - start while busy=1 is ignored; the in-flight operation and latched operands are unaffected.
  - Operand/is_signed changes after acceptance have no effect.
  - product changes only on the edge entering DONE; it is stable during RUN of the next operation until the next DONE.
- Width rules:
  - A at WIDTH+2 bits guarantees no overflow for every operand pair, including signed −2^(WIDTH−1) × −2^(WIDTH−1) and unsigned full-scale.
  - Result is exact in 2*WIDTH bits for both modes.
- Simultaneous rst_n=0 and start=1: reset wins.

Decomposition:
- Shared package `booth_pkg`:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Width-derivation helper: counter width = $clog2(WIDTH+2).
- One natural sub-module: `booth_step`, purely combinational. Inputs A, Q, q_m1, M; outputs the next {A,Q,q_m1} (add/sub select plus arithmetic shift), parametrised by WIDTH. The top holds FSM, counter and registers.

Test Plan (WIDTH=8):
- Signed extremes: is_signed=1, a=0x80, b=0x80 → product=0x4000, done exactly 10 cycles after the start edge, busy high 9 cycles.
- Unsigned full-scale: is_signed=0, a=0xFF, b=0xFF → product=0xFE01. Same stimulus with is_signed=1 → 0x0001.
- Mixed signs: is_signed=1, a=0x7F, b=0x80 → 0xC080; a=0xFF, b=0x01 → 0xFFFF; a=0x00, b=0xAB → 0x0000.
- Start during busy: start a=3, b=5, then pulse start with a=9, b=9 at RUN cycle 4 → only one done, product=0x000F; ready=0 throughout RUN.
- Back-to-back: assert start in the DONE cycle with a=0xFE, b=0x03 signed → first result is held, second done 10 cycles later with product=0xFFFA.
- Reset mid-op: rst_n=0 at RUN cycle 5 → next cycle ready=1, busy=0, done=0, product=0; no done pulse follows. A fresh op after reset returns the correct result.
- Random: 10k random operand/mode pairs vs. a reference model, WIDTH ∈ {4, 8, 16}.
